// File: rtl/input_entry_ctrl_pkg.sv
// input_entry_ctrl_pkg
//   Shared types and constants for the operator numeric-entry controller:
//   FSM state encoding, cursor positions, BCD limits, and small helpers for
//   saturating BCD steps and sign/BCD-to-two's-complement conversion.
package input_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] CUR_SIGN = 2'd0;
  localparam logic [1:0] CUR_HUN  = 2'd1;
  localparam logic [1:0] CUR_TEN  = 2'd2;
  localparam logic [1:0] CUR_ONE  = 2'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // One saturating step of a BCD digit: never wraps past 9 or below 0.
  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    logic [3:0] r;
    if (up) r = (d >= BCD_MAX) ? BCD_MAX : d + 4'd1;
    else    r = (d == 4'd0) ? 4'd0 : d - 4'd1;
    return r;
  endfunction

  // Sign + three BCD digits -> 32-bit two's complement. The magnitude fits
  // in 11 bits (max 999), so negation is done there and then sign-extended.
  // A negative zero naturally comes out as 0.
  function automatic logic [31:0] bcd_to_value(input logic       neg,
                                               input logic [3:0] hun,
                                               input logic [3:0] ten,
                                               input logic [3:0] one);
    logic [10:0] mag;
    logic [10:0] v;
    mag = 11'(hun) * 11'd100 + 11'(ten) * 11'd10 + 11'(one);
    v   = neg ? (11'd0 - mag) : mag;
    return {{21{v[10]}}, v};
  endfunction

endpackage

// File: rtl/input_entry_ctrl_key_repeat.sv
// input_key_repeat
//   Press/auto-repeat event generator for one debounced button level.
//   Emits a single-cycle key_event on the first tick the button is seen high,
//   again once it has been held REPEAT_DLY ticks, then every REPEAT_RATE
//   ticks for as long as it stays high. Releasing clears both counters.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   tick       - button-sample strobe; everything happens on tick cycles
//   level      - debounced button level
//   key_event  - combinational event, valid only in a tick cycle
module input_key_repeat
  #(
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
  )
  (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic level,
    output logic key_event
  );

  localparam int HW = (REPEAT_DLY  > 1) ? $clog2(REPEAT_DLY + 1)  : 1;
  localparam int RW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE + 1) : 1;
  localparam logic [HW-1:0] DLY_V     = HW'(REPEAT_DLY);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  // held_reg: consecutive high ticks seen so far, saturating at REPEAT_DLY.
  // Zero means the previous tick sampled the button low.
  logic [HW-1:0] held_reg;
  // rate_reg: ticks since the last repeat event once past the delay.
  logic [RW-1:0] rate_reg;

  always_comb begin
    key_event = 1'b0;
    if (tick && level) begin
      if (held_reg < DLY_V)
        key_event = (held_reg == '0) || (held_reg + HW'(1) == DLY_V);
      else
        key_event = (rate_reg == RATE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_reg <= '0;
      rate_reg <= '0;
    end else if (tick) begin
      if (!level) begin
        held_reg <= '0;
        rate_reg <= '0;
      end else if (held_reg < DLY_V) begin
        held_reg <= held_reg + HW'(1);
        rate_reg <= '0;
      end else begin
        rate_reg <= (rate_reg == RATE_LAST) ? '0 : rate_reg + RW'(1);
      end
    end
  end

endmodule

// File: rtl/input_entry_ctrl.sv
// input_entry_ctrl
//   Operator numeric entry: the CPU pulses edit_req, the operator edits a
//   sign digit and three BCD digits with inc/dec/next, enter commits the
//   signed value which is then offered to the CPU over val_valid/val_ack.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   btn_inc/dec/next/enter           - debounced button levels
//   edit_req                         - one-cycle CPU request to start entry
//   val_ack                          - CPU has consumed the committed value
//   val_valid, value                 - committed value handshake (32-bit signed)
//   sign, d_hun, d_ten, d_one        - current entry for the display
//   cursor, digit_sel                - selected digit (binary and one-hot)
//   editing                          - high while the entry is being edited
module input_entry_ctrl
  import input_entry_ctrl_pkg::*;
  #(
    parameter int TICK_DIV    = 120,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
  )
  (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_next,
    input  logic        btn_enter,
    input  logic        edit_req,
    input  logic        val_ack,
    output logic        val_valid,
    output logic [31:0] value,
    output logic        sign,
    output logic [3:0]  d_hun,
    output logic [3:0]  d_ten,
    output logic [3:0]  d_one,
    output logic [1:0]  cursor,
    output logic [3:0]  digit_sel,
    output logic        editing
  );

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt_reg;
  logic          tick;
  state_t        state_reg;
  logic          next_prev_reg;
  logic          enter_prev_reg;
  logic          next_ev;
  logic          enter_ev;
  logic [1:0]    key_level;
  logic [1:0]    key_ev;
  logic          inc_ev;
  logic          dec_ev;

  assign tick     = (tick_cnt_reg == TICK_LAST);
  // next/enter have no auto-repeat: a plain rising edge between ticks.
  assign next_ev  = tick && btn_next  && !next_prev_reg;
  assign enter_ev = tick && btn_enter && !enter_prev_reg;

  // Index 0 = inc, index 1 = dec.
  assign key_level = {btn_dec, btn_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      input_key_repeat #(
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
      ) u_key_repeat (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .level     (key_level[gi]),
        .key_event (key_ev[gi])
      );
    end
  endgenerate

  assign inc_ev = key_ev[0];
  assign dec_ev = key_ev[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg   <= '0;
      state_reg      <= ST_IDLE;
      next_prev_reg  <= 1'b0;
      enter_prev_reg <= 1'b0;
      val_valid      <= 1'b0;
      value          <= '0;
      sign           <= 1'b0;
      d_hun          <= '0;
      d_ten          <= '0;
      d_one          <= '0;
      cursor         <= CUR_SIGN;
      digit_sel      <= 4'b0001;
      editing        <= 1'b0;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TW'(1);

      // Previous samples track the buttons in every state so that a button
      // already held when editing starts does not count as a fresh press.
      if (tick) begin
        next_prev_reg  <= btn_next;
        enter_prev_reg <= btn_enter;
      end

      case (state_reg)
        ST_IDLE: begin
          if (edit_req) begin
            state_reg <= ST_EDIT;
            editing   <= 1'b1;
            cursor    <= CUR_SIGN;
            digit_sel <= 4'b0001;
          end
        end

        ST_EDIT: begin
          // enter > next > inc/dec; inc and dec together cancel out.
          if (enter_ev) begin
            value     <= bcd_to_value(sign, d_hun, d_ten, d_one);
            val_valid <= 1'b1;
            editing   <= 1'b0;
            state_reg <= ST_COMMIT;
          end else if (next_ev) begin
            cursor    <= cursor + 2'd1;
            digit_sel <= {digit_sel[2:0], digit_sel[3]};
          end else if (inc_ev != dec_ev) begin
            case (cursor)
              CUR_SIGN: sign  <= inc_ev;
              CUR_HUN:  d_hun <= bcd_step(d_hun, inc_ev);
              CUR_TEN:  d_ten <= bcd_step(d_ten, inc_ev);
              CUR_ONE:  d_one <= bcd_step(d_one, inc_ev);
              default:  sign  <= sign;
            endcase
          end
        end

        ST_COMMIT: begin
          if (val_valid && val_ack) begin
            val_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_entry_ctrl.sv
// tb_input_entry_ctrl
//   Self-checking bench: directed scenarios plus random button activity.
//   A transaction-level model predicts the entry state and pushes expected
//   committed values into a queue; a monitor pops them when val_valid rises.
module tb_input_entry_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DLY      = 5;
  localparam int RATE     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_inc = 1'b0, btn_dec = 1'b0, btn_next = 1'b0, btn_enter = 1'b0;
  logic        edit_req = 1'b0, val_ack = 1'b0;
  logic        val_valid;
  logic [31:0] value;
  logic        sign;
  logic [3:0]  d_hun, d_ten, d_one;
  logic [1:0]  cursor;
  logic [3:0]  digit_sel;
  logic        editing;

  input_entry_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .REPEAT_DLY  (DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .btn_next  (btn_next),
    .btn_enter (btn_enter),
    .edit_req  (edit_req),
    .val_ack   (val_ack),
    .val_valid (val_valid),
    .value     (value),
    .sign      (sign),
    .d_hun     (d_hun),
    .d_ten     (d_ten),
    .d_one     (d_one),
    .cursor    (cursor),
    .digit_sel (digit_sel),
    .editing   (editing)
  );

  always #5 clk = ~clk;

  // Bench-side time base: which cycles are sample ticks.
  int bcnt = 0;
  always @(posedge clk) begin
    if (rst) bcnt <= 0;
    else     bcnt <= (bcnt == TICK_DIV - 1) ? 0 : bcnt + 1;
  end

  // Reference model: 0 = idle, 1 = editing, 2 = committed.
  // m_dig[0] is the sign digit (range 0..1), m_dig[1..3] are hun/ten/one.
  int          m_state;
  int          m_dig[4];
  int          m_cur;
  logic [31:0] m_value;
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic check_disp(input string tag);
    chk({tag, ".sign"},      32'(sign),      32'(m_dig[0]));
    chk({tag, ".hun"},       32'(d_hun),     32'(m_dig[1]));
    chk({tag, ".ten"},       32'(d_ten),     32'(m_dig[2]));
    chk({tag, ".one"},       32'(d_one),     32'(m_dig[3]));
    chk({tag, ".cursor"},    32'(cursor),    32'(m_cur));
    chk({tag, ".digit_sel"}, 32'(digit_sel), 32'(1 << m_cur));
    chk({tag, ".editing"},   32'(editing),   32'(m_state == 1));
    chk({tag, ".val_valid"}, 32'(val_valid), 32'(m_state == 2));
    chk({tag, ".value"},     value,          m_value);
  endtask

  // Number of inc/dec events produced by holding a button k ticks.
  function automatic int n_events(input int k);
    int n = 1;
    if (k >= DLY) n += 1 + (k - DLY) / RATE;
    return n;
  endfunction

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  // Return 1 time unit after the next tick edge.
  task automatic wait_tick();
    @(negedge clk);
    while (bcnt != TICK_DIV - 1) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cur   = 0;
    m_value = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_disp(tag);
  endtask

  // Hold the given buttons for k ticks, release, and let one low tick pass.
  task automatic hold(input logic i, input logic d, input logic n, input int k, input string tag);
    int ev;
    btn_inc = i; btn_dec = d; btn_next = n;
    repeat (k) wait_tick();
    btn_inc = 1'b0; btn_dec = 1'b0; btn_next = 1'b0;
    wait_tick();
    if (m_state == 1) begin
      ev = n_events(k);
      if (n) begin
        m_cur = (m_cur + 1) % 4;
        ev    = ev - 1;          // the first inc/dec event lost to next
      end
      if (i && d) ev = 0;
      if (i != d && (i || d)) begin
        if (i) m_dig[m_cur] = clamp(m_dig[m_cur] + ev, (m_cur == 0) ? 1 : 9);
        else   m_dig[m_cur] = clamp(m_dig[m_cur] - ev, (m_cur == 0) ? 1 : 9);
      end
    end
    check_disp(tag);
  endtask

  task automatic pulse_edit(input string tag);
    edit_req = 1'b1;
    @(posedge clk);
    #1;
    edit_req = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
      m_cur   = 0;
    end
    check_disp(tag);
  endtask

  task automatic commit(input string tag);
    int mag;
    btn_enter = 1'b1;
    @(negedge clk);
    while (bcnt != TICK_DIV - 1) @(negedge clk);
    chk({tag, ".valid_before"}, 32'(val_valid), 32'(m_state == 2));
    @(posedge clk);
    #1;
    if (m_state == 1) begin
      mag     = 100 * m_dig[1] + 10 * m_dig[2] + m_dig[3];
      m_value = (m_dig[0] != 0) ? -mag : mag;
      m_state = 2;
      exp_q.push_back(m_value);
    end
    chk({tag, ".valid_latency"}, 32'(val_valid), 32'(m_state == 2));
    btn_enter = 1'b0;
    wait_tick();
    check_disp(tag);
  endtask

  task automatic do_ack(input int n, input string tag);
    val_ack = 1'b1;
    @(posedge clk);
    #1;
    if (m_state == 2) m_state = 0;
    chk({tag, ".valid_drop"}, 32'(val_valid), 32'd0);
    repeat (n - 1) @(posedge clk);
    #1;
    val_ack = 1'b0;
    check_disp(tag);
  endtask

  // Monitor: each rising val_valid must carry the next predicted value,
  // and the value must stay put while val_valid is held.
  logic [31:0] mon_exp = '0;
  logic        prev_v  = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (val_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL commit_unexpected: got 0x%0h required no commit", value);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("commit_value", value, mon_exp);
          end
        end else if (val_valid && prev_v) begin
          chk("value_stable", value, mon_exp);
        end
        prev_v = val_valid;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    int k;

    model_reset();
    repeat (2) @(posedge clk);
    do_reset("reset_init");

    // Basic entry 327 and handshake.
    pulse_edit("start1");
    hold(0, 0, 1, 1, "next");
    repeat (3) hold(1, 0, 0, 1, "inc_hun");
    hold(0, 0, 1, 1, "next");
    repeat (2) hold(1, 0, 0, 1, "inc_ten");
    hold(0, 0, 1, 1, "next");
    repeat (7) hold(1, 0, 0, 1, "inc_one");
    commit("commit327");
    chk("value327", value, 32'd327);
    do_ack(3, "ack327");

    // Negative value -45.
    pulse_edit("start2");
    hold(1, 0, 0, 1, "sign_inc");
    hold(0, 0, 1, 1, "next");
    repeat (3) hold(0, 1, 0, 1, "dec_hun");
    hold(0, 0, 1, 1, "next");
    repeat (2) hold(1, 0, 0, 1, "inc_ten");
    hold(0, 0, 1, 1, "next");
    repeat (2) hold(0, 1, 0, 1, "dec_one");
    commit("commit_m45");
    chk("value_m45", value, 32'hFFFF_FFD3);
    do_ack(2, "ack_m45");

    // Negative zero.
    pulse_edit("start3");
    hold(0, 0, 1, 1, "next");
    hold(0, 0, 1, 1, "next");
    repeat (4) hold(0, 1, 0, 1, "dec_ten");
    hold(0, 0, 1, 1, "next");
    repeat (5) hold(0, 1, 0, 1, "dec_one");
    commit("commit_negzero");
    chk("value_negzero", value, 32'd0);
    do_ack(1, "ack_negzero");

    // Saturation and cursor wrap.
    pulse_edit("start4");
    repeat (3) hold(0, 0, 1, 1, "next");
    repeat (12) hold(1, 0, 0, 1, "sat_inc");
    chk("sat_hi", 32'(d_one), 32'd9);
    repeat (2) hold(0, 0, 1, 1, "next");
    repeat (3) hold(0, 1, 0, 1, "sat_dec");
    chk("sat_lo", 32'(d_hun), 32'd0);
    repeat (3) hold(0, 0, 1, 1, "next");
    repeat (5) hold(0, 0, 1, 1, "wrap");
    chk("wrap_cursor", 32'(cursor), 32'd1);
    chk("wrap_sel", 32'(digit_sel), 32'b0010);

    // Auto-repeat on ten.
    hold(0, 0, 1, 1, "next");
    hold(1, 0, 0, 11, "repeat11");
    chk("repeat_ten", 32'(d_ten), 32'd5);
    hold(1, 0, 0, 1, "repress");
    chk("repress_ten", 32'(d_ten), 32'd6);

    // Priority and ignored inputs.
    hold(1, 1, 0, 3, "inc_dec");
    hold(1, 0, 1, 1, "next_inc");
    pulse_edit("edit_in_edit");
    commit("commit_m69");
    hold(1, 0, 0, 1, "inc_in_commit");
    hold(0, 0, 1, 1, "next_in_commit");
    pulse_edit("edit_in_commit");
    commit("enter_in_commit");
    do_ack(3, "ack_m69");
    hold(1, 0, 0, 2, "inc_in_idle");
    hold(0, 0, 1, 1, "next_in_idle");
    commit("enter_in_idle");
    do_ack(1, "ack_in_idle");

    // Random activity.
    for (int r = 0; r < 40; r++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: begin k = $urandom_range(1, 12); hold(1, 0, 0, k, "rnd_inc"); end
        2:    begin k = $urandom_range(1, 12); hold(0, 1, 0, k, "rnd_dec"); end
        3:    begin k = $urandom_range(1, 3);  hold(0, 0, 1, k, "rnd_next"); end
        4:    begin k = $urandom_range(1, 4);  hold(1, 1, 0, k, "rnd_incdec"); end
        default: begin
          if (m_state == 1)      commit("rnd_commit");
          else if (m_state == 2) do_ack($urandom_range(1, 3), "rnd_ack");
          else                   pulse_edit("rnd_edit");
        end
      endcase
    end
    if (m_state == 2) do_ack(1, "rnd_final_ack");

    // Reset mid-edit with digits 1/2/3.
    do_reset("reset_pre");
    pulse_edit("start5");
    hold(0, 0, 1, 1, "next");
    hold(1, 0, 0, 1, "inc_hun");
    hold(0, 0, 1, 1, "next");
    repeat (2) hold(1, 0, 0, 1, "inc_ten");
    hold(0, 0, 1, 1, "next");
    repeat (3) hold(1, 0, 0, 1, "inc_one");
    do_reset("reset_edit");

    // Reset while a committed value is pending.
    pulse_edit("start6");
    hold(0, 0, 1, 1, "next");
    hold(1, 0, 0, 1, "inc_hun");
    commit("commit100");
    do_reset("reset_commit");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
